lsu_arb: RTL and testbench
==========================

LSU_ARB -- requirements
Module: lsu_arb

Interface
REQ-001 Parameter: P_FIXED_PRIO, default 0, meaning 0 = round-robin arbitration, 1 = m0 always wins.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mN_req  input  1  (N=0 core, N=1 aux/debug) request, level, held until mN_gnt.
REQ-005 mN_addr  input  16; mN_wdata  input  32; mN_we  input  1; mN_bmask  input  4; mN_ldsel  input  3  transaction fields, valid while mN_req=1.
REQ-006 mN_gnt  output  1  one-cycle pulse, request fields captured this cycle.
REQ-007 mN_rvalid  output  1  one-cycle completion pulse, for reads and writes.
REQ-008 mN_rdata  output  32  read data, valid while mN_rvalid=1, else 0.
REQ-009 lsu_addr  output  16; lsu_w_data  output  32; lsu_wr_en  output  1; lsu_bmask  output  4; lsu_ld_sel  output  3  shared LSU port.
REQ-010 lsu_r_data  input  32  LSU read data, valid one clock after lsu_addr is stable.

Function
REQ-011 FSM states: IDLE, ACC, RSP.
- IDLE: if any mN_req=1, pick winner, pulse its gnt, latch fields and owner id, go to ACC; else stay.
REQ-012 ACC, one cycle: drive latched fields on LSU port; lsu_wr_en = latched we; go to RSP.
REQ-013 RSP, one cycle: hold lsu_addr, lsu_ld_sel and lsu_bmask; lsu_wr_en=0; owner rvalid=1.
- Owner rdata = lsu_r_data on a read, 0 on a write.
REQ-014 RSP with a pending request: arbitrate, pulse gnt, latch and go to ACC directly, else IDLE.
- Back-to-back throughput is one transaction per 2 cycles; first grant to rvalid is 2 cycles.
REQ-015 lsu_wr_en SHALL be high for exactly one cycle per granted write and never outside ACC.
REQ-016 Outside ACC/RSP, all lsu_* outputs = 0.
REQ-017 Non-owner rvalid/rdata = 0 at all times; gnt is never asserted to both masters in one cycle.
REQ-018 Round-robin (P_FIXED_PRIO=0):
- Both requesting: grant the master not granted last.
- Single requester: grant it.
- Last-grant pointer updates only on a grant.
REQ-019 P_FIXED_PRIO=1: m0 wins every conflict; m1 may starve, and this is legal.
REQ-020 A request deasserted before its gnt SHALL produce no transaction.
- Field changes after gnt SHALL not affect the in-flight transaction.
REQ-021 Fields are latched as-is: no address decode, no bmask/ld_sel checking.

Reset
REQ-022 rst=1 immediately forces IDLE, all outputs 0, and the last-grant pointer to m1.
- First conflict after reset goes to m0.
REQ-023 rst during ACC SHALL drop lsu_wr_en asynchronously.
- The aborted transaction gets no rvalid; the master must re-request.

Structure
REQ-024 Package lsu_arb_pkg SHALL hold:
- State enum.
- Master-id type, 1 bit.
- Packed request struct: addr, wdata, we, bmask, ldsel.
- Constants ST_IDLE/ST_ACC/ST_RSP.
REQ-025 Sub-module lsu_rr_pick: combinational 2-way picker (req[1:0], last, fixed_prio) -> winner id and valid.
- Pointer register stays in lsu_arb.

Verification
REQ-026 Single read: m0 reads 0x7000 with ld_sel=010 after m0 writes 0x12345678 with bmask 1111.
- m0_gnt at T, lsu_wr_en=0, m0_rvalid at T+2 with rdata=0x12345678.
REQ-027 Single write: m1 writes 0xDEADBEEF to 0x7010 with bmask 1111.
- lsu_wr_en high exactly one cycle.
- m1_rvalid with rdata=0.
- Later m0 read of 0x7010 returns 0xDEADBEEF.
REQ-028 Contention, RR: both masters hold requests for 6 transactions.
- Grant order m0,m1,m0,m1,m0,m1.
- Grants 2 cycles apart, no IDLE cycles between them.
REQ-029 Contention, P_FIXED_PRIO=1: both masters request for 3 transactions -> m0 granted 3 times, m1_gnt stays 0.
REQ-030 Early withdrawal: m1_req pulsed 1 cycle while m0 owns the port -> no m1_gnt, no LSU activity for m1.
REQ-031 Reset mid-write: assert rst during ACC of a write.
- lsu_wr_en falls before the next edge.
- No rvalid.
- After release, m0 wins the first conflict.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types for the two-master LSU arbiter: FSM states, master id and the
// latched request record.
package lsu_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_RSP  = 2'd2
   } state_e;

   typedef logic mid_t;

   localparam mid_t MID_M0 = 1'b0;
   localparam mid_t MID_M1 = 1'b1;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  bmask;
      logic [2:0]  ldsel;
   } req_t;

endpackage

// File: rtl/lsu_rr_pick.sv
// Combinational 2-way picker: round-robin against the last winner, or m0
// always wins when fixed priority is selected.
module lsu_rr_pick
   import lsu_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  mid_t       i_last,
   input  logic       i_fixed_prio,
   output mid_t       o_win,
   output logic       o_valid
);

   always_comb begin
      o_valid = |i_req;
      o_win   = MID_M0;
      if (i_req == 2'b11) begin
         o_win = i_fixed_prio ? MID_M0 : ~i_last;
      end else if (i_req[1]) begin
         o_win = MID_M1;
      end
   end

endmodule

// File: rtl/lsu_arb.sv
// Two-master arbiter for a single LSU port. Each transaction takes ACC (drive
// the port) then RSP (return data); RSP may grant the next one directly.
module lsu_arb
   import lsu_arb_pkg::*;
#(
   parameter int P_FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic [15:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m0_we,
   input  logic [3:0]  m0_bmask,
   input  logic [2:0]  m0_ldsel,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic [15:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_we,
   input  logic [3:0]  m1_bmask,
   input  logic [2:0]  m1_ldsel,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic [15:0] lsu_addr,
   output logic [31:0] lsu_w_data,
   output logic        lsu_wr_en,
   output logic [3:0]  lsu_bmask,
   output logic [2:0]  lsu_ld_sel,
   input  logic [31:0] lsu_r_data,
   output state_e      o_dbg_state
);

   state_e r_state;
   state_e w_next;
   mid_t   r_owner;
   mid_t   r_last;
   req_t   r_req;

   req_t   w_m0_fields;
   req_t   w_m1_fields;
   mid_t   w_win;
   logic   w_win_valid;
   logic   w_grant;
   logic   w_busy;

   assign w_m0_fields = {m0_addr, m0_wdata, m0_we, m0_bmask, m0_ldsel};
   assign w_m1_fields = {m1_addr, m1_wdata, m1_we, m1_bmask, m1_ldsel};

   lsu_rr_pick u_pick (
      .i_req        ({m1_req, m0_req}),
      .i_last       (r_last),
      .i_fixed_prio (P_FIXED_PRIO != 0),
      .o_win        (w_win),
      .o_valid      (w_win_valid)
   );

   // Grants are combinational from the live requests; rst masks them so that
   // every output is quiet while reset is held.
   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_grant = w_win_valid && !rst;
            if (w_win_valid) w_next = ST_ACC;
         end
         ST_ACC: w_next = ST_RSP;
         ST_RSP: begin
            w_grant = w_win_valid && !rst;
            w_next  = w_win_valid ? ST_ACC : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_owner <= MID_M0;
         r_last  <= MID_M1;
         r_req   <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_owner <= w_win;
            r_last  <= w_win;
            r_req   <= (w_win == MID_M1) ? w_m1_fields : w_m0_fields;
         end
      end
   end

   assign w_busy = (r_state == ST_ACC) || (r_state == ST_RSP);

   always_comb begin
      m0_gnt     = w_grant && (w_win == MID_M0);
      m1_gnt     = w_grant && (w_win == MID_M1);
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      m0_rdata   = '0;
      m1_rdata   = '0;
      lsu_addr   = '0;
      lsu_w_data = '0;
      lsu_wr_en  = 1'b0;
      lsu_bmask  = '0;
      lsu_ld_sel = '0;
      if (w_busy) begin
         lsu_addr   = r_req.addr;
         lsu_bmask  = r_req.bmask;
         lsu_ld_sel = r_req.ldsel;
      end
      if (r_state == ST_ACC) begin
         lsu_w_data = r_req.wdata;
         lsu_wr_en  = r_req.we;
      end
      // Writes complete with a zero data word.
      if (r_state == ST_RSP) begin
         if (r_owner == MID_M0) begin
            m0_rvalid = 1'b1;
            m0_rdata  = r_req.we ? 32'd0 : lsu_r_data;
         end else begin
            m1_rvalid = 1'b1;
            m1_rdata  = r_req.we ? 32'd0 : lsu_r_data;
         end
      end
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_arb.sv
// Directed bench for lsu_arb: one round-robin and one fixed-priority instance
// share master stimulus, each backed by its own registered-read memory.
module tb_lsu_arb;
   import lsu_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic [15:0] m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic        m0_we = 1'b0, m1_we = 1'b0;
   logic [3:0]  m0_bmask = '0, m1_bmask = '0;
   logic [2:0]  m0_ldsel = '0, m1_ldsel = '0;

   logic        rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid, rr_lsu_wr_en;
   logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_lsu_w_data, rr_lsu_r_data;
   logic [15:0] rr_lsu_addr;
   logic [3:0]  rr_lsu_bmask;
   logic [2:0]  rr_lsu_ld_sel;
   state_e      rr_st;

   logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_lsu_wr_en;
   logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_lsu_w_data, fp_lsu_r_data;
   logic [15:0] fp_lsu_addr;
   logic [3:0]  fp_lsu_bmask;
   logic [2:0]  fp_lsu_ld_sel;
   state_e      fp_st;

   logic [31:0] mem_rr [0:65535];
   logic [31:0] mem_fp [0:65535];

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lsu_arb #(.P_FIXED_PRIO(0)) u_rr (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_bmask(m0_bmask), .m0_ldsel(m0_ldsel),
      .m0_gnt(rr_m0_gnt), .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_bmask(m1_bmask), .m1_ldsel(m1_ldsel),
      .m1_gnt(rr_m1_gnt), .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata),
      .lsu_addr(rr_lsu_addr), .lsu_w_data(rr_lsu_w_data), .lsu_wr_en(rr_lsu_wr_en),
      .lsu_bmask(rr_lsu_bmask), .lsu_ld_sel(rr_lsu_ld_sel), .lsu_r_data(rr_lsu_r_data),
      .o_dbg_state(rr_st)
   );

   lsu_arb #(.P_FIXED_PRIO(1)) u_fp (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_bmask(m0_bmask), .m0_ldsel(m0_ldsel),
      .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_bmask(m1_bmask), .m1_ldsel(m1_ldsel),
      .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
      .lsu_addr(fp_lsu_addr), .lsu_w_data(fp_lsu_w_data), .lsu_wr_en(fp_lsu_wr_en),
      .lsu_bmask(fp_lsu_bmask), .lsu_ld_sel(fp_lsu_ld_sel), .lsu_r_data(fp_lsu_r_data),
      .o_dbg_state(fp_st)
   );

   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem_rr[a] = '0;
         mem_fp[a] = '0;
      end
   end

   // Read data appears one clock after the address is presented.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (rr_lsu_wr_en && rr_lsu_bmask[b]) mem_rr[rr_lsu_addr][8*b +: 8] <= rr_lsu_w_data[8*b +: 8];
         if (fp_lsu_wr_en && fp_lsu_bmask[b]) mem_fp[fp_lsu_addr][8*b +: 8] <= fp_lsu_w_data[8*b +: 8];
      end
      rr_lsu_r_data <= mem_rr[rr_lsu_addr];
      fp_lsu_r_data <= mem_fp[fp_lsu_addr];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int m, input logic rq, input logic [15:0] a, input logic [31:0] wd,
                          input logic we, input logic [3:0] bm, input logic [2:0] ls);
      if (m == 0) begin
         m0_req = rq; m0_addr = a; m0_wdata = wd; m0_we = we; m0_bmask = bm; m0_ldsel = ls;
      end else begin
         m1_req = rq; m1_addr = a; m1_wdata = wd; m1_we = we; m1_bmask = bm; m1_ldsel = ls;
      end
   endtask

   // One isolated transaction; called just after a rising edge with the DUT idle.
   task automatic run_txn(input int m, input logic [15:0] a, input logic [31:0] wd, input logic we,
                          input logic [3:0] bm, input logic [2:0] ls, input logic [31:0] exp_rd);
      logic got;
      got = 1'b0;
      set_req(m, 1'b1, a, wd, we, bm, ls);
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         got = (m == 0) ? rr_m0_gnt : rr_m1_gnt;
         if (!got) tick();
      end
      chk("txn_gnt", {31'd0, got}, 32'd1);
      chk("txn_other_gnt", {31'd0, (m == 0) ? rr_m1_gnt : rr_m0_gnt}, 32'd0);
      chk("txn_idle_wr_en", {31'd0, rr_lsu_wr_en}, 32'd0);
      tick();
      // Scramble fields after the grant; the in-flight transaction must not see it.
      set_req(m, 1'b0, 16'hFFFF, ~wd, ~we, 4'h0, 3'b111);
      @(negedge clk);
      chk("acc_addr", {16'd0, rr_lsu_addr}, {16'd0, a});
      chk("acc_wr_en", {31'd0, rr_lsu_wr_en}, {31'd0, we});
      chk("acc_wdata", rr_lsu_w_data, wd);
      chk("acc_rvalid", {30'd0, rr_m1_rvalid, rr_m0_rvalid}, 32'd0);
      tick();
      @(negedge clk);
      chk("rsp_rvalid", {30'd0, rr_m1_rvalid, rr_m0_rvalid}, (m == 0) ? 32'd1 : 32'd2);
      chk("rsp_rdata", (m == 0) ? rr_m0_rdata : rr_m1_rdata, exp_rd);
      chk("rsp_other_rdata", (m == 0) ? rr_m1_rdata : rr_m0_rdata, 32'd0);
      chk("rsp_wr_en", {31'd0, rr_lsu_wr_en}, 32'd0);
      chk("rsp_addr", {16'd0, rr_lsu_addr}, {16'd0, a});
      chk("rsp_ldsel", {29'd0, rr_lsu_ld_sel}, {29'd0, ls});
      chk("fp_rsp_rdata", (m == 0) ? fp_m0_rdata : fp_m1_rdata, exp_rd);
      tick();
   endtask

   initial begin
      logic [1:0] exp_g;
      int         fp_m0_cnt;
      int         fp_m1_cnt;

      // Reset: a live request must not leak a grant while rst is held.
      m0_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_state", {30'd0, rr_st}, {30'd0, ST_IDLE});
      chk("rst_gnt", {30'd0, rr_m1_gnt, rr_m0_gnt}, 32'd0);
      chk("rst_lsu_addr", {16'd0, rr_lsu_addr}, 32'd0);
      chk("rst_rvalid", {30'd0, rr_m1_rvalid, rr_m0_rvalid}, 32'd0);
      m0_req = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      run_txn(0, 16'h7000, 32'h12345678, 1'b1, 4'hF, 3'b000, 32'h0);
      run_txn(0, 16'h7000, 32'h0,        1'b0, 4'hF, 3'b010, 32'h12345678);
      run_txn(1, 16'h7010, 32'hDEADBEEF, 1'b1, 4'hF, 3'b000, 32'h0);
      run_txn(0, 16'h7010, 32'h0,        1'b0, 4'hF, 3'b010, 32'hDEADBEEF);

      // m1 requests only during m0's ACC cycle, then withdraws.
      set_req(0, 1'b1, 16'h7000, 32'h0, 1'b0, 4'hF, 3'b010);
      @(negedge clk);
      chk("wd_m0_gnt", {31'd0, rr_m0_gnt}, 32'd1);
      tick();
      set_req(0, 1'b0, 16'h0, 32'h0, 1'b0, 4'h0, 3'b000);
      set_req(1, 1'b1, 16'h7030, 32'h55AA55AA, 1'b1, 4'hF, 3'b000);
      @(negedge clk);
      chk("wd_acc_m1_gnt", {31'd0, rr_m1_gnt}, 32'd0);
      chk("wd_acc_addr", {16'd0, rr_lsu_addr}, 32'h7000);
      tick();
      set_req(1, 1'b0, 16'h0, 32'h0, 1'b0, 4'h0, 3'b000);
      @(negedge clk);
      chk("wd_rsp_m1_gnt", {31'd0, rr_m1_gnt}, 32'd0);
      chk("wd_rsp_m0_rdata", rr_m0_rdata, 32'h12345678);
      tick();
      @(negedge clk);
      chk("wd_idle_state", {30'd0, rr_st}, {30'd0, ST_IDLE});
      chk("wd_idle_addr", {16'd0, rr_lsu_addr}, 32'd0);
      chk("wd_idle_m1_rvalid", {31'd0, rr_m1_rvalid}, 32'd0);
      chk("wd_mem_untouched", mem_rr[16'h7030], 32'd0);
      tick();

      // Reset in the middle of an m1 write's ACC cycle.
      set_req(1, 1'b1, 16'h7020, 32'hCAFEF00D, 1'b1, 4'hF, 3'b000);
      @(negedge clk);
      chk("rw_m1_gnt", {31'd0, rr_m1_gnt}, 32'd1);
      tick();
      set_req(1, 1'b0, 16'h0, 32'h0, 1'b0, 4'h0, 3'b000);
      chk("rw_acc_wr_en", {31'd0, rr_lsu_wr_en}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rw_async_wr_en", {31'd0, rr_lsu_wr_en}, 32'd0);
      chk("rw_async_state", {30'd0, rr_st}, {30'd0, ST_IDLE});
      @(negedge clk);
      tick();
      chk("rw_no_rvalid", {30'd0, rr_m1_rvalid, rr_m0_rvalid}, 32'd0);
      chk("rw_mem_aborted", mem_rr[16'h7020], 32'd0);
      rst = 1'b0;

      // Both masters hold requests from the cycle reset releases.
      set_req(0, 1'b1, 16'h7000, 32'h0, 1'b0, 4'hF, 3'b010);
      set_req(1, 1'b1, 16'h7010, 32'h0, 1'b0, 4'hF, 3'b010);
      fp_m0_cnt = 0;
      fp_m1_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k % 2 == 0) exp_g = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
         else            exp_g = 2'b00;
         chk($sformatf("rr_gnt_%0d", k), {30'd0, rr_m1_gnt, rr_m0_gnt}, {30'd0, exp_g});
         if (k >= 2 && k % 2 == 0) begin
            if (((k / 2) - 1) % 2 == 0)
               chk($sformatf("rr_rd_m0_%0d", k), rr_m0_rdata, 32'h12345678);
            else
               chk($sformatf("rr_rd_m1_%0d", k), rr_m1_rdata, 32'hDEADBEEF);
         end
         if (k < 6 && fp_m0_gnt) fp_m0_cnt++;
         if (fp_m1_gnt) fp_m1_cnt++;
         tick();
      end
      set_req(0, 1'b0, 16'h0, 32'h0, 1'b0, 4'h0, 3'b000);
      set_req(1, 1'b0, 16'h0, 32'h0, 1'b0, 4'h0, 3'b000);
      chk("fp_m0_grants", fp_m0_cnt, 32'd3);
      chk("fp_m1_grants", fp_m1_cnt, 32'd0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
